pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_tx.sv | 137 +++++++++++++
 tb/tb_pattern_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// MSB-first serial frame transmitter with repeat count and registered outputs.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit after each frame.
module pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       rpt,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  localparam int S_IDLE  = 0;
  localparam int S_SHIFT = 1;
  localparam int S_DONE  = 2;
`ifdef PATTERN_TX_PARITY_EN
  localparam int S_PAR   = 3;
  localparam int NS      = 4;
`else
  localparam int NS      = 3;
`endif
  localparam int IW = $clog2(WIDTH);

  typedef logic [NS-1:0] state_t;

  localparam state_t IDLE  = state_t'(1 << S_IDLE);
  localparam state_t SHIFT = state_t'(1 << S_SHIFT);
  localparam state_t DONE  = state_t'(1 << S_DONE);
`ifdef PATTERN_TX_PARITY_EN
  localparam state_t PAR   = state_t'(1 << S_PAR);
`endif

  state_t           state, nstate;
  logic [WIDTH-1:0] frame, n_frame;
  logic [WIDTH-1:0] sh, n_sh;
  logic [3:0]       rcnt, n_rcnt;
  logic [IW-1:0]    idx, n_idx;
  logic             n_dout, n_dvalid, n_busy, n_done;
  logic             last, more, restart;

  assign last = (idx == IW'(WIDTH - 1));
  assign more = (rcnt != 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      frame  <= '0;
      sh     <= '0;
      rcnt   <= '0;
      idx    <= '0;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nstate;
      frame  <= n_frame;
      sh     <= n_sh;
      rcnt   <= n_rcnt;
      idx    <= n_idx;
      dout   <= n_dout;
      dvalid <= n_dvalid;
      busy   <= n_busy;
      done   <= n_done;
    end
  end

  always_comb begin
    nstate = IDLE;
    unique case (1'b1)
      state[S_IDLE]: nstate = start ? SHIFT : IDLE;
      state[S_SHIFT]: begin
        if (!last)
          nstate = SHIFT;
        else
`ifdef PATTERN_TX_PARITY_EN
          nstate = PAR;
`else
          nstate = more ? SHIFT : DONE;
`endif
      end
`ifdef PATTERN_TX_PARITY_EN
      state[S_PAR]: nstate = more ? SHIFT : DONE;
`endif
      state[S_DONE]: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // A new frame of a repeat starts straight from the latched copy.
`ifdef PATTERN_TX_PARITY_EN
  assign restart = nstate[S_SHIFT] & state[S_PAR];
`else
  assign restart = nstate[S_SHIFT] & state[S_SHIFT] & last;
`endif

  always_comb begin
    n_frame  = frame;
    n_sh     = sh;
    n_rcnt   = rcnt;
    n_idx    = idx;
    n_dout   = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
    n_dvalid = nstate[S_SHIFT] | nstate[S_PAR];
`else
    n_dvalid = nstate[S_SHIFT];
`endif
    n_busy   = n_dvalid;
    n_done   = nstate[S_DONE];
    if (state[S_IDLE] && start) begin
      n_frame = pattern;
      n_rcnt  = rpt;
      n_idx   = '0;
      n_dout  = pattern[WIDTH-1];
      n_sh    = {pattern[WIDTH-2:0], 1'b0};
    end else if (restart) begin
      n_rcnt  = rcnt - 4'd1;
      n_idx   = '0;
      n_dout  = frame[WIDTH-1];
      n_sh    = {frame[WIDTH-2:0], 1'b0};
    end else if (state[S_SHIFT] && !last) begin
      n_idx   = idx + IW'(1);
      n_dout  = sh[WIDTH-1];
      n_sh    = sh << 1;
    end
`ifdef PATTERN_TX_PARITY_EN
    else if (nstate[S_PAR]) begin
      n_dout  = ^frame;
    end
`endif
  end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: vector table plus multi-cycle sequences.
// Output tuples are compared as {dout,dvalid,busy,done}.
module tb_pattern_tx;

  localparam int W = 8;
`ifdef PATTERN_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [3:0]   rpt = '0;
  logic         dout, dvalid, busy, done;

  int passed = 0;
  int total  = 0;

  pattern_tx #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pattern(pattern), .rpt(rpt),
    .dout(dout), .dvalid(dvalid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         st;
    logic [W-1:0] pat;
    logic [3:0]   r;
    logic [3:0]   exp;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(logic st, logic [W-1:0] pat,
                              logic [3:0] r, logic [3:0] exp);
    vec_t v;
    v.st = st; v.pat = pat; v.r = r; v.exp = exp;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outputs c edges after the accepting edge.
  function automatic logic [3:0] model(logic [W-1:0] p, int r, int c);
    int tot;
    int pos;
    tot = (r + 1) * FL;
    if (c < tot) begin
      pos = c % FL;
      if (pos < W) return {p[W-1-pos], 3'b110};
      return {^p, 3'b110};
    end
    if (c == tot) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic run_tx(string name, logic [W-1:0] p, logic [3:0] r);
    int tot;
    tot = (int'(r) + 1) * FL;
    pattern = p;
    rpt = r;
    start = 1'b1;
    tick;
    start = 1'b0;
    pattern = ~p;
    rpt = ~r;
    for (int c = 0; c <= tot + 1; c++) begin
      if (c > 0) tick;
      check(name, {dout, dvalid, busy, done}, model(p, int'(r), c));
    end
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 8'h55, 4'd0, 4'b0110);
    tbl[1]  = mk(1'b0, 8'h55, 4'd0, 4'b1110);
    tbl[2]  = mk(1'b0, 8'h55, 4'd0, 4'b0110);
    tbl[3]  = mk(1'b0, 8'h55, 4'd0, 4'b1110);
    tbl[4]  = mk(1'b0, 8'h55, 4'd0, 4'b0110);
    tbl[5]  = mk(1'b0, 8'h55, 4'd0, 4'b1110);
    tbl[6]  = mk(1'b0, 8'h55, 4'd0, 4'b0110);
    tbl[7]  = mk(1'b0, 8'h55, 4'd0, 4'b1110);
    tbl[8]  = mk(1'b0, 8'h55, 4'd0, 4'b0001);
    tbl[9]  = mk(1'b0, 8'h55, 4'd0, 4'b0000);
    tbl[10] = mk(1'b1, 8'h00, 4'd0, 4'b0110);
    tbl[11] = mk(1'b0, 8'h00, 4'd0, 4'b0110);
    tbl[12] = mk(1'b0, 8'h00, 4'd0, 4'b0110);
    tbl[13] = mk(1'b0, 8'h00, 4'd0, 4'b0110);
    tbl[14] = mk(1'b1, 8'hFF, 4'd3, 4'b0110);
    tbl[15] = mk(1'b1, 8'hFF, 4'd3, 4'b0110);
    tbl[16] = mk(1'b1, 8'hFF, 4'd3, 4'b0110);
    tbl[17] = mk(1'b1, 8'hFF, 4'd3, 4'b0110);
    tbl[18] = mk(1'b1, 8'hFF, 4'd3, 4'b0001);
    tbl[19] = mk(1'b1, 8'hFF, 4'd3, 4'b0000);
    tbl[20] = mk(1'b0, 8'h00, 4'd0, 4'b0000);

    #1;
    check("reset_async", {dout, dvalid, busy, done}, 4'b0000);
    tick;
    check("reset_held", {dout, dvalid, busy, done}, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    tick;
    check("idle_after_reset", {dout, dvalid, busy, done}, 4'b0000);

`ifndef PATTERN_TX_PARITY_EN
    for (int i = 0; i < 21; i++) begin
      start = tbl[i].st;
      pattern = tbl[i].pat;
      rpt = tbl[i].r;
      tick;
      check($sformatf("vec%0d", i), {dout, dvalid, busy, done}, tbl[i].exp);
    end
    start = 1'b0;
`endif

    run_tx("rpt2_contig", 8'h55, 4'd2);
    run_tx("rpt15_max", 8'h3C, 4'd15);
    run_tx("rpt1_mixed", 8'hB2, 4'd1);
`ifdef PATTERN_TX_PARITY_EN
    run_tx("parity", 8'h07, 4'd1);
`endif

    pattern = 8'hC3;
    rpt = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick;
    check("mid_bit4", {dout, dvalid, busy, done}, model(8'hC3, 0, 4));
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_cycle", {dout, dvalid, busy, done}, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick;
      check("rst_no_done", {dout, dvalid, busy, done}, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b1;
    pattern = 8'h81;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("post_rst_accept", {dout, dvalid, busy, done}, model(8'h81, 0, 0));
    for (int c = 1; c <= FL + 1; c++) begin
      tick;
      check("post_rst_tx", {dout, dvalid, busy, done}, model(8'h81, 0, c));
    end

    pattern = 8'hA5;
    rpt = 4'd0;
    start = 1'b1;
    for (int k = 0; k < 3 * (FL + 2); k++) begin
      tick;
      check($sformatf("held_start_e%0d", k), {dout, dvalid, busy, done},
            model(8'hA5, 0, k % (FL + 2)));
    end
    start = 1'b0;
    tick;
    check("held_start_release", {dout, dvalid, busy, done}, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
